cpu_control: RTL and testbench
==============================

# cpu_control

Multi-cycle control unit that drives the CPU datapath. It reads the current `instr` and `zero` flag from the datapath and sequences `PC_sel`, `PC_lden`, `rf_wren`, `rf_wrdata_sel`, `rf_b_sel`, `ALU_bin_sel`, `ALU_func` and `MEM_wren` through a Moore FSM, one instruction at a time. Together with the datapath it forms the processor top level.

## Interface
- No parameters.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `instr` input 32: current instruction from the fetch stage.
- `zero` input 1: ALU zero flag.
- `PC_sel` output 1: 0 selects PC+4; 1 selects PC+4+immed.
- `PC_lden` output 1: PC load enable.
- `rf_wren` output 1: register-file write enable.
- `rf_wrdata_sel` output 1: 0 writes ALU result; 1 writes memory data.
- `rf_b_sel` output 1: 0 reads register B from instr[15:11]; 1 reads it from instr[20:16].
- `ALU_bin_sel` output 1: ALU B operand; 0 = rfB, 1 = immed.
- `ALU_func` output 4: ALU operation.
- `MEM_wren` output 1: data-memory write enable.
- `instr_done` output 1: one-cycle pulse in the last cycle of each instruction.
- `illegal` output 1: unknown-opcode flag (see Configuration).

## Operation
- Opcode is instr[31:26]:
  - 100000 R-type; ALU_func = instr[3:0].
  - 110000 addi; 110011 ori; 111000 li. All three are ALU-immediate.
  - 000000 beq; 000001 bne; 111111 b.
  - 001111 lw; 011111 sw.
- Any other opcode is illegal.
- ALU codes: 0000 add, 0001 sub, 0011 or.
- States: S_RST, S_IF, S_DEC, S_EX, S_MEM, S_WB, S_BR, S_HALT.
- Transitions:
  - S_RST → S_IF.
  - S_IF → S_DEC.
  - From S_DEC:
    - Branch goes to S_BR.
    - R-type, immediate, lw and sw go to S_EX.
    - Illegal goes to S_HALT when the trap is enabled, otherwise to S_IF as a NOP.
  - From S_EX: lw and sw go to S_MEM; R-type and immediate go to S_WB.
  - From S_MEM: lw goes to S_WB; sw goes to S_IF.
  - S_WB → S_IF.
  - S_BR → S_IF.
  - S_HALT stays in S_HALT until reset.
- Outputs per state. Moore outputs, except that ALU_func and the sel lines are decoded from the latched opcode.
  - S_EX:
    - R-type: ALU_bin_sel=0, rf_b_sel=0.
    - addi: ALU_bin_sel=1, ALU_func=0000.
    - ori: ALU_bin_sel=1, ALU_func=0011.
    - li: ALU_bin_sel=1, ALU_func=0000.
    - lw and sw: ALU_bin_sel=1, ALU_func=0000, rf_b_sel=1.
    - beq and bne in S_BR: ALU_bin_sel=0, ALU_func=0001, rf_b_sel=1.
  - S_MEM: sw drives MEM_wren=1, PC_lden=1, PC_sel=0 and instr_done=1.
  - S_WB: rf_wren=1, PC_lden=1, PC_sel=0, instr_done=1. rf_wrdata_sel is 1 for lw and 0 otherwise.
  - S_BR: PC_lden=1, instr_done=1. PC_sel is set as follows:
    - b: 1.
    - beq: equal to zero.
    - bne: equal to ~zero.
  - NOP exit from S_DEC: the S_DEC cycle asserts PC_lden=1, PC_sel=0 and instr_done=1.
- The opcode is latched at the S_IF→S_DEC edge. Later changes to instr cannot alter the instruction in flight.

## Timing
- Latencies, from entering S_IF to the instr_done cycle inclusive:
  - R-type and immediate: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch: 3 cycles.
  - NOP: 2 cycles.
- PC_lden is high for exactly one cycle per instruction, and only in the instr_done cycle.
- rf_wren and MEM_wren are never high in the same cycle.
- At most one of rf_wren or MEM_wren is high per instruction.
- `zero` is sampled only in S_BR.
- Reset:
  - While reset is high, and in the cycle after it is released (S_RST), every output is 0. This includes ALU_func=0000 and illegal=0.
  - S_IF starts in the second cycle after reset drops.
  - Reset asserted mid-instruction aborts it at the next edge, with no write enable or PC load issued.
  - Reset overrides S_HALT.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode moves S_DEC → S_HALT.
  - `illegal` stays 1 in S_HALT until reset.
  - In S_HALT all enables are 0 and no instr_done pulse is issued.
- Undefined:
  - An illegal opcode executes as a 2-cycle NOP.
  - S_HALT is unreachable.
  - `illegal` is tied to 0.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 through S_RST; S_IF in the second cycle after release; first PC_lden in the S_DEC-exit or completion cycle.
- instr=0x80000000 | func 0001 (R-type sub) → ALU_func=0001 in S_EX; cycle 4 has rf_wren=1, rf_wrdata_sel=0, PC_lden=1, instr_done=1.
- lw (opcode 001111) → 5 cycles; S_WB has rf_wrdata_sel=1, rf_wren=1; MEM_wren stays 0 throughout.
- sw (opcode 011111) → cycle 4 has MEM_wren=1, PC_lden=1, rf_wren=0.
- beq with zero=1, then beq with zero=0, then bne with zero=0 → S_BR drives PC_sel=1, 0, 1 respectively; 3 cycles each.
- Opcode 010101, plus reset asserted during S_EX of an addi:
  - Opcode 010101 with the macro defined → illegal=1 and no PC_lden thereafter until reset.
  - Opcode 010101 without the macro → 2-cycle NOP with PC_sel=0.
  - Reset during S_EX of addi → no rf_wren, and S_RST follows.

Source files
------------

// File: rtl/cpu_control.sv
// Multi-cycle Moore control unit sequencing the CPU datapath one instruction at a time.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to halt on unknown opcodes (default: execute as NOP).
//
// state  | meaning
// S_RST  | post-reset idle cycle, all outputs low
// S_IF   | fetch; opcode and func latched on exit
// S_DEC  | decode; illegal opcode completes here as a NOP (trap disabled)
// S_EX   | ALU operation for R-type, immediate, lw, sw
// S_MEM  | data-memory access; sw completes here
// S_WB   | register-file write-back, instruction completes
// S_BR   | branch resolution using zero, instruction completes
// S_HALT | illegal-opcode trap, left only by reset
module cpu_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        PC_sel,
    output logic        PC_lden,
    output logic        rf_wren,
    output logic        rf_wrdata_sel,
    output logic        rf_b_sel,
    output logic        ALU_bin_sel,
    output logic [3:0]  ALU_func,
    output logic        MEM_wren,
    output logic        instr_done,
    output logic        illegal
);

    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_IF   = 3'd1;
    localparam logic [2:0] S_DEC  = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;
    localparam logic [2:0] S_BR   = 3'd6;
    localparam logic [2:0] S_HALT = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [5:0] op_q;
    logic [3:0] func_q;

    logic is_rtype;
    logic is_imm;
    logic is_lw;
    logic is_sw;
    logic is_br;
    logic is_alu;

    logic [3:0] alu_func_dec;
    logic       alu_bin_dec;
    logic       rf_b_dec;
    logic       br_taken;

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[25:4];

    assign is_rtype = (op_q == OP_RTYPE);
    assign is_imm   = (op_q == OP_ADDI) || (op_q == OP_ORI) || (op_q == OP_LI);
    assign is_lw    = (op_q == OP_LW);
    assign is_sw    = (op_q == OP_SW);
    assign is_br    = (op_q == OP_BEQ) || (op_q == OP_BNE) || (op_q == OP_B);
    assign is_alu   = is_rtype || is_imm;

    // Opcode and func are captured once so later instr changes cannot affect the instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_RST;
            op_q   <= 6'd0;
            func_q <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IF) begin
                op_q   <= instr[31:26];
                func_q <= instr[3:0];
            end
        end
    end

    always_comb begin
        state_nxt = S_RST;
        case (state)
            S_RST: state_nxt = S_IF;
            S_IF:  state_nxt = S_DEC;
            S_DEC: begin
                if (is_br)
                    state_nxt = S_BR;
                else if (is_alu || is_lw || is_sw)
                    state_nxt = S_EX;
                else
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_nxt = S_HALT;
`else
                    state_nxt = S_IF;
`endif
            end
            S_EX:   state_nxt = (is_lw || is_sw) ? S_MEM : S_WB;
            S_MEM:  state_nxt = is_lw ? S_WB : S_IF;
            S_WB:   state_nxt = S_IF;
            S_BR:   state_nxt = S_IF;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_RST;
        endcase
    end

    always_comb begin
        alu_func_dec = ALU_ADD;
        alu_bin_dec  = 1'b0;
        rf_b_dec     = 1'b0;
        case (op_q)
            OP_RTYPE: alu_func_dec = func_q;
            OP_ADDI, OP_LI: alu_bin_dec = 1'b1;
            OP_ORI: begin
                alu_bin_dec  = 1'b1;
                alu_func_dec = ALU_OR;
            end
            OP_LW, OP_SW: begin
                alu_bin_dec = 1'b1;
                rf_b_dec    = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_B: begin
                alu_func_dec = ALU_SUB;
                rf_b_dec     = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (op_q)
            OP_B:   br_taken = 1'b1;
            OP_BEQ: br_taken = zero;
            OP_BNE: br_taken = ~zero;
            default: br_taken = 1'b0;
        endcase
    end

    // ALU controls are held from S_EX through write-back so the datapath result stays stable
    always_comb begin
        PC_sel        = 1'b0;
        PC_lden       = 1'b0;
        rf_wren       = 1'b0;
        rf_wrdata_sel = 1'b0;
        rf_b_sel      = 1'b0;
        ALU_bin_sel   = 1'b0;
        ALU_func      = ALU_ADD;
        MEM_wren      = 1'b0;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        case (state)
            S_DEC: begin
`ifndef CTRL_ILLEGAL_TRAP_EN
                if (!is_br && !is_alu && !is_lw && !is_sw) begin
                    PC_lden    = 1'b1;
                    instr_done = 1'b1;
                end
`endif
            end
            S_EX: begin
                rf_b_sel    = rf_b_dec;
                ALU_bin_sel = alu_bin_dec;
                ALU_func    = alu_func_dec;
            end
            S_MEM: begin
                rf_b_sel    = rf_b_dec;
                ALU_bin_sel = alu_bin_dec;
                ALU_func    = alu_func_dec;
                if (is_sw) begin
                    MEM_wren   = 1'b1;
                    PC_lden    = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_WB: begin
                rf_b_sel      = rf_b_dec;
                ALU_bin_sel   = alu_bin_dec;
                ALU_func      = alu_func_dec;
                rf_wren       = 1'b1;
                rf_wrdata_sel = is_lw;
                PC_lden       = 1'b1;
                instr_done    = 1'b1;
            end
            S_BR: begin
                rf_b_sel    = rf_b_dec;
                ALU_bin_sel = alu_bin_dec;
                ALU_func    = alu_func_dec;
                PC_sel      = br_taken;
                PC_lden     = 1'b1;
                instr_done  = 1'b1;
            end
            S_HALT: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                illegal = 1'b1;
`endif
            end
            default: ;
        endcase
        // Gating on reset keeps an aborted instruction from issuing a write or PC load in its last cycle
        if (reset) begin
            PC_sel        = 1'b0;
            PC_lden       = 1'b0;
            rf_wren       = 1'b0;
            rf_wrdata_sel = 1'b0;
            rf_b_sel      = 1'b0;
            ALU_bin_sel   = 1'b0;
            ALU_func      = ALU_ADD;
            MEM_wren      = 1'b0;
            instr_done    = 1'b0;
            illegal       = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: per-cycle comparison against an instruction-level model
// plus literal expectations on recorded per-instruction traces.
module tb_cpu_control;

    typedef struct packed {
        logic       pc_sel;
        logic       pc_lden;
        logic       rf_wren;
        logic       rf_wrdata_sel;
        logic       rf_b_sel;
        logic       alu_bin_sel;
        logic [3:0] alu_func;
        logic       mem_wren;
        logic       instr_done;
        logic       illegal;
    } out_t;

    localparam int C_R = 0, C_ADDI = 1, C_ORI = 2, C_LI = 3, C_BEQ = 4, C_BNE = 5,
                   C_B = 6, C_LW = 7, C_SW = 8, C_ILL = 9;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        PC_sel, PC_lden, rf_wren, rf_wrdata_sel, rf_b_sel, ALU_bin_sel;
    logic [3:0]  ALU_func;
    logic        MEM_wren, instr_done, illegal;

    out_t  dut_o;
    out_t  exp_o;
    out_t  trace [1:8];
    bit    chk_en = 1'b0;
    string cur_name = "reset";
    int    cur_k = 0;
    int    checks = 0;
    int    errors = 0;

    cpu_control dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .PC_sel(PC_sel), .PC_lden(PC_lden), .rf_wren(rf_wren),
        .rf_wrdata_sel(rf_wrdata_sel), .rf_b_sel(rf_b_sel), .ALU_bin_sel(ALU_bin_sel),
        .ALU_func(ALU_func), .MEM_wren(MEM_wren), .instr_done(instr_done), .illegal(illegal)
    );

    assign dut_o = {PC_sel, PC_lden, rf_wren, rf_wrdata_sel, rf_b_sel, ALU_bin_sel,
                    ALU_func, MEM_wren, instr_done, illegal};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (dut_o !== exp_o) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs got %h want %h", cur_name, cur_k, dut_o, exp_o);
            end
        end
    end

    function automatic int cls_of(input logic [5:0] op);
        case (op)
            6'b100000: return C_R;
            6'b110000: return C_ADDI;
            6'b110011: return C_ORI;
            6'b111000: return C_LI;
            6'b000000: return C_BEQ;
            6'b000001: return C_BNE;
            6'b111111: return C_B;
            6'b001111: return C_LW;
            6'b011111: return C_SW;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic int latency(input int cls);
        case (cls)
            C_LW:               return 5;
            C_SW:               return 4;
            C_BEQ, C_BNE, C_B:  return 3;
            C_ILL:              return TRAP ? 0 : 2;
            default:            return 4;
        endcase
    endfunction

    // Expected outputs in cycle k (1 = fetch cycle) of an instruction of class cls
    function automatic out_t model(input int cls, input logic [3:0] func, input int k, input logic z);
        out_t o;
        bit   done;
        bit   is_br;
        o     = '0;
        is_br = (cls == C_BEQ) || (cls == C_BNE) || (cls == C_B);
        if (cls == C_ILL && TRAP) begin
            o.illegal = (k >= 3);
            return o;
        end
        done         = (k == latency(cls));
        o.instr_done = done;
        o.pc_lden    = done;
        o.rf_wren    = done && (cls == C_R || cls == C_ADDI || cls == C_ORI || cls == C_LI || cls == C_LW);
        o.rf_wrdata_sel = done && (cls == C_LW);
        o.mem_wren   = done && (cls == C_SW);
        if (done && is_br)
            o.pc_sel = (cls == C_B) ? 1'b1 : (cls == C_BEQ) ? z : ~z;
        if (k >= 3 && cls != C_ILL) begin
            case (cls)
                C_R:          o.alu_func = func;
                C_ADDI, C_LI: o.alu_bin_sel = 1'b1;
                C_ORI: begin o.alu_bin_sel = 1'b1; o.alu_func = 4'b0011; end
                C_LW, C_SW: begin o.alu_bin_sel = 1'b1; o.rf_b_sel = 1'b1; end
                default: begin o.alu_func = 4'b0001; o.rf_b_sel = 1'b1; end
            endcase
        end
        return o;
    endfunction

    task automatic check_lit(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        cur_name = "reset";
        reset    = 1'b1;
        exp_o    = '0;
        chk_en   = 1'b1;
        for (int i = 0; i < n; i++) begin
            cur_k = i;
            tick();
        end
        reset = 1'b0;
        cur_name = "post_reset_S_RST";
        exp_o = '0;
        tick();
    endtask

    // abort_k > 0 raises reset in that cycle and ends the instruction there
    task automatic run_instr(input string name, input logic [5:0] op, input logic [3:0] func,
                             input logic z, input int abort_k);
        int cls;
        int n;
        cls      = cls_of(op);
        n        = (cls == C_ILL && TRAP) ? 6 : latency(cls);
        cur_name = name;
        for (int k = 1; k <= n; k++) begin
            cur_k = k;
            instr = (k == 1) ? {op, 22'h15a5a, func} : $urandom;
            zero  = (k == 3) ? z : 1'($urandom_range(0, 1));
            exp_o = model(cls, func, k, z);
            if (abort_k != 0 && k == abort_k) begin
                reset = 1'b1;
                exp_o = '0;
            end
            @(negedge clk);
            #1;
            trace[k] = dut_o;
            @(posedge clk);
            #1;
            if (abort_k != 0 && k == abort_k) break;
        end
    endtask

    initial begin
        reset = 1'b1;
        instr = 32'd0;
        zero  = 1'b0;
        exp_o = '0;
        do_reset(3);

        run_instr("rtype_sub", 6'b100000, 4'b0001, 1'b0, 0);
        check_lit("sub_alu_func_ex", trace[3].alu_func, 4'b0001);
        check_lit("sub_rf_wren_c4", {3'b0, trace[4].rf_wren}, 4'd1);
        check_lit("sub_wrdata_sel_c4", {3'b0, trace[4].rf_wrdata_sel}, 4'd0);
        check_lit("sub_pc_lden_c4", {3'b0, trace[4].pc_lden}, 4'd1);
        check_lit("sub_done_c4", {3'b0, trace[4].instr_done}, 4'd1);

        run_instr("rtype_or", 6'b100000, 4'b0011, 1'b1, 0);
        run_instr("addi", 6'b110000, 4'b1010, 1'b0, 0);
        run_instr("ori", 6'b110011, 4'b0101, 1'b0, 0);
        check_lit("ori_alu_func_ex", trace[3].alu_func, 4'b0011);
        run_instr("li", 6'b111000, 4'b1111, 1'b1, 0);

        run_instr("lw", 6'b001111, 4'b0110, 1'b0, 0);
        check_lit("lw_wrdata_sel_c5", {3'b0, trace[5].rf_wrdata_sel}, 4'd1);
        check_lit("lw_rf_wren_c5", {3'b0, trace[5].rf_wren}, 4'd1);
        check_lit("lw_no_mem_wren", {3'b0, trace[1].mem_wren | trace[2].mem_wren | trace[3].mem_wren
                                          | trace[4].mem_wren | trace[5].mem_wren}, 4'd0);

        run_instr("sw", 6'b011111, 4'b0000, 1'b0, 0);
        check_lit("sw_mem_wren_c4", {3'b0, trace[4].mem_wren}, 4'd1);
        check_lit("sw_pc_lden_c4", {3'b0, trace[4].pc_lden}, 4'd1);
        check_lit("sw_rf_wren_c4", {3'b0, trace[4].rf_wren}, 4'd0);

        run_instr("beq_z1", 6'b000000, 4'b0000, 1'b1, 0);
        check_lit("beq_z1_pc_sel", {3'b0, trace[3].pc_sel}, 4'd1);
        run_instr("beq_z0", 6'b000000, 4'b0000, 1'b0, 0);
        check_lit("beq_z0_pc_sel", {3'b0, trace[3].pc_sel}, 4'd0);
        run_instr("bne_z0", 6'b000001, 4'b0000, 1'b0, 0);
        check_lit("bne_z0_pc_sel", {3'b0, trace[3].pc_sel}, 4'd1);
        run_instr("bne_z1", 6'b000001, 4'b0000, 1'b1, 0);
        run_instr("b_z0", 6'b111111, 4'b0000, 1'b0, 0);
        check_lit("b_pc_sel", {3'b0, trace[3].pc_sel}, 4'd1);

        run_instr("illegal_010101", 6'b010101, 4'b0011, 1'b1, 0);
        if (TRAP) begin
            check_lit("trap_illegal", {3'b0, trace[6].illegal}, 4'd1);
            check_lit("trap_no_pc_lden", {3'b0, trace[3].pc_lden | trace[4].pc_lden
                                               | trace[5].pc_lden | trace[6].pc_lden}, 4'd0);
            do_reset(2);
        end else begin
            check_lit("nop_pc_lden_c2", {3'b0, trace[2].pc_lden}, 4'd1);
            check_lit("nop_pc_sel_c2", {3'b0, trace[2].pc_sel}, 4'd0);
        end
        run_instr("addi_after_illegal", 6'b110000, 4'b0000, 1'b0, 0);

        run_instr("addi_abort", 6'b110000, 4'b0000, 1'b0, 3);
        check_lit("abort_no_rf_wren", {3'b0, trace[3].rf_wren}, 4'd0);
        do_reset(1);
        run_instr("addi_after_abort", 6'b110000, 4'b0000, 1'b0, 0);
        check_lit("post_abort_done_c4", {3'b0, trace[4].instr_done}, 4'd1);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
